mouse_bounds_sequencer: RTL

//  Shares the single config bus of the mouse controller between two requesters.
//  - Client 0 is the menu logic; client 1 is the game logic.
//  - The config bus is value plus the setmax_x/setmax_y/setmin_x/setmin_y/setx/sety strobes.
//  - Arbitrates round-robin, latches the winner's bounding box and derives cursor-adjusted limits.
//  - Emits one strobe per write in a fixed order, then acks the client.

---
 rtl/mouse_bounds_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mouse_bounds_sequencer.sv
// mouse_bounds_sequencer: round-robin sharing of the mouse config bus between menu and game clients
module mouse_bounds_sequencer #(
   parameter int CURSOR_SIZE = 16,
   parameter int X_LIM       = 1019,
   parameter int Y_LIM       = 763,
   parameter int GAP         = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req,
   input  logic [1:0]  recenter,
   input  logic [11:0] min_x0,
   input  logic [11:0] max_x0,
   input  logic [11:0] min_y0,
   input  logic [11:0] max_y0,
   input  logic [11:0] min_x1,
   input  logic [11:0] max_x1,
   input  logic [11:0] min_y1,
   input  logic [11:0] max_y1,
   output logic [11:0] value,
   output logic        setmax_x,
   output logic        setmax_y,
   output logic        setmin_x,
   output logic        setmin_y,
   output logic        setx,
   output logic        sety,
   output logic [1:0]  ack,
   output logic        busy
);
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WRITE, ST_GAP} state_t;
   localparam logic [12:0] CS = 13'(CURSOR_SIZE);
   localparam logic [12:0] XL = 13'(X_LIM);
   localparam logic [12:0] YL = 13'(Y_LIM);
   localparam logic [7:0]  GL = 8'(GAP - 1);
   state_t      state, nxt;
   logic        g, last_grant, rc, grant, gsel, done;
   logic [11:0] mnx, mxx, mny, mxy, wv, nval, cxh, cyh;
   logic [12:0] ax, ay, bx, by;
   logic [2:0]  idx;
   logic [7:0]  gcnt;
   logic [5:0]  str, nstr;
   logic [1:0]  nack;

   function automatic logic [12:0] lim_max(input logic [12:0] mn, input logic [12:0] mx, input logic [12:0] l);
      logic [12:0] t;
      t = (mx >= mn + CS) ? mx - CS : mn;
      return (t > l) ? l : t;
   endfunction

   assign grant = state == ST_IDLE && !busy && |req;
   assign gsel  = (req == 2'b10) | (req == 2'b11 & ~last_grant);
   assign ax    = lim_max({1'b0, mnx}, {1'b0, mxx}, XL);
   assign ay    = lim_max({1'b0, mny}, {1'b0, mxy}, YL);
   assign bx    = ({1'b0, mnx} > ax) ? ax : {1'b0, mnx};
   assign by    = ({1'b0, mny} > ay) ? ay : {1'b0, mny};
   assign cxh   = 12'((bx + ax) >> 1);
   assign cyh   = 12'((by + ay) >> 1);
   assign done  = idx == (rc ? 3'd5 : 3'd3);
   assign {sety, setx, setmin_y, setmin_x, setmax_y, setmax_x} = str;

   // state register
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= ST_IDLE;
      else state <= nxt;

   // next state: grant, capture, then walk the writes with optional idle gaps
   always_comb
      nxt = state == ST_IDLE  ? (grant ? ST_LOAD : ST_IDLE) :
            state == ST_LOAD  ? ST_WRITE :
            state == ST_WRITE ? (done ? ST_IDLE : (GAP == 0 ? ST_WRITE : ST_GAP)) :
                                (gcnt == GL ? ST_WRITE : ST_GAP);

   // output decode: strobe, data and ack for the write issued this cycle
   always_comb begin
      wv   = idx == 3'd0 ? ax[11:0] : idx == 3'd1 ? ay[11:0] : idx == 3'd2 ? bx[11:0] :
             idx == 3'd3 ? by[11:0] : idx == 3'd4 ? cxh : cyh;
      nstr = state == ST_WRITE ? 6'd1 << idx : 6'd0;
      nval = state == ST_WRITE ? wv : 12'd0;
      nack = (state == ST_WRITE && done) ? (g ? 2'b10 : 2'b01) : 2'b00;
   end

   // registered bus outputs; busy spans grant up to the cycle after ack
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         str   <= 6'd0;
         value <= 12'd0;
         ack   <= 2'b00;
         busy  <= 1'b0;
      end else begin
         str   <= nstr;
         value <= nval;
         ack   <= nack;
         busy  <= grant ? 1'b1 : (|ack ? 1'b0 : busy);
      end

   // arbitration memory, bundle capture and write/gap counters
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         g          <= 1'b0;
         last_grant <= 1'b1;
         {mnx, mxx, mny, mxy} <= '0;
         rc         <= 1'b0;
         idx        <= 3'd0;
         gcnt       <= 8'd0;
      end else begin
         if (grant) begin
            g          <= gsel;
            last_grant <= gsel;
         end
         if (state == ST_LOAD) begin
            mnx <= g ? min_x1 : min_x0;
            mxx <= g ? max_x1 : max_x0;
            mny <= g ? min_y1 : min_y0;
            mxy <= g ? max_y1 : max_y0;
            rc  <= recenter[g];
            idx <= 3'd0;
         end
         if (state == ST_WRITE) begin
            idx  <= idx + 3'd1;
            gcnt <= 8'd0;
         end
         if (state == ST_GAP) gcnt <= gcnt + 8'd1;
      end
endmodule
